// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: mode selects and FSM states.
package usr_pkg;

  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] USR_HOLD = 3'b000;
  localparam logic [SEL_W-1:0] USR_SHR  = 3'b001;
  localparam logic [SEL_W-1:0] USR_SHL  = 3'b010;
  localparam logic [SEL_W-1:0] USR_LOAD = 3'b011;
  localparam logic [SEL_W-1:0] USR_ROR  = 3'b100;
  localparam logic [SEL_W-1:0] USR_ROL  = 3'b101;
  localparam logic [SEL_W-1:0] USR_ASR  = 3'b110;
  localparam logic [SEL_W-1:0] USR_RSVD = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } usr_state_e;

  // True for the modes that a burst may repeat.
  function automatic logic is_shift_op(input logic [SEL_W-1:0] op);
    return (op == USR_SHR) || (op == USR_SHL) || (op == USR_ROR) ||
           (op == USR_ROL) || (op == USR_ASR);
  endfunction

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational next-value generator shared by single-step and burst paths.
module usr_shift_unit
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [SEL_W-1:0] op_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic             left_in_i,
  input  logic             right_in_i,
  input  logic [WIDTH-1:0] parallel_i,
  output logic [WIDTH-1:0] next_c
);

  // Select the next register value for the requested mode.
  always_comb begin
    next_c = cur_i;
    case (op_i)
      USR_SHR:  next_c = {right_in_i, cur_i[WIDTH-1:1]};
      USR_SHL:  next_c = {cur_i[WIDTH-2:0], left_in_i};
      USR_LOAD: next_c = parallel_i;
      USR_ROR:  next_c = {cur_i[0], cur_i[WIDTH-1:1]};
      USR_ROL:  next_c = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
      USR_ASR:  next_c = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
      default:  next_c = cur_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_register_n.sv
// Universal shift register with single-step modes and a counted burst mode.
module universal_shift_register_n
  import usr_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic             left_in,
  input  logic             right_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] out,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  usr_state_e       state_q, state_d;
  logic [SEL_W-1:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;

  logic [SEL_W-1:0] unit_op;
  logic [WIDTH-1:0] unit_next;
  logic [CNT_W-1:0] shamt_clamped;

  // Burst steps replay the latched op; otherwise the live select drives the unit.
  assign unit_op       = (state_q == BUSY) ? op_q : sel;
  assign shamt_clamped = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;

  usr_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .op_i       (unit_op),
    .cur_i      (data_q),
    .left_in_i  (left_in),
    .right_in_i (right_in),
    .parallel_i (parallel_in),
    .next_c     (unit_next)
  );

  // State, counter, data and done registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      op_q    <= USR_HOLD;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: enable freeze, burst step, start handling, single step.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (!en) begin
      done_d = 1'b0;
    end else if (state_q == BUSY) begin
      data_d = unit_next;
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      if (is_shift_op(sel)) begin
        op_d  = sel;
        cnt_d = shamt_clamped;
        if (shamt_clamped == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end else if (sel == USR_LOAD) begin
        data_d = unit_next;
        done_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end else begin
      data_d = unit_next;
    end
  end

  assign out    = data_q;
  assign sout_l = data_q[WIDTH-1];
  assign sout_r = data_q[0];
  assign busy   = (state_q == BUSY);
  assign done   = done_q;

endmodule
